// File: rtl/decimal_entry_nbit.sv
// Decimal keypad entry: accumulates BCD digits into a binary value, published on commit.
// Optional seven-segment echo of entered digits when DECIMAL_ENTRY_ECHO_EN is defined.
module decimal_entry_nbit #(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned VALUE_WIDTH = $clog2(10**NUM_DIGITS)
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic [3:0]                       digit_in,
  input  logic                             digit_valid,
  output logic                             digit_ready,
  input  logic                             commit,
  input  logic                             clear,
  output logic [VALUE_WIDTH-1:0]           value,
  output logic                             value_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
`ifdef DECIMAL_ENTRY_ECHO_EN
  output logic                             digit_error,
  output logic [NUM_DIGITS-1:0][6:0]       echo_seg
`else
  output logic                             digit_error
`endif
);

  localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {StEntry, StCalc, StFull} state_e;

  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [3:0]             digit_q, digit_d;
  logic                   pend_q, pend_d;
  logic                   vv_q, vv_d;
  logic                   err_q, err_d;
  logic                   transfer;
  logic [VALUE_WIDTH-1:0] acc_x10;

`ifdef DECIMAL_ENTRY_ECHO_EN
  logic [NUM_DIGITS-1:0][6:0] echo_q, echo_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction
`endif

  assign digit_ready = (state_q == StEntry) & ~commit & ~clear & n_reset;
  assign transfer    = digit_valid & digit_ready;
  assign cnt_inc     = cnt_q + CntW'(1);
  // acc holds at most NUM_DIGITS-1 digits here, so x10+digit always fits the width
  assign acc_x10     = (acc_q << 3) + (acc_q << 1) + VALUE_WIDTH'(digit_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    pend_d  = pend_q;
    vv_d    = 1'b0;
    err_d   = 1'b0;
`ifdef DECIMAL_ENTRY_ECHO_EN
    echo_d  = echo_q;
`endif
    if (clear) begin
      state_d = StEntry;
      acc_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
`ifdef DECIMAL_ENTRY_ECHO_EN
      echo_d  = '0;
`endif
    end else begin
      case (state_q)
        StCalc: begin
          acc_d   = acc_x10;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CntW'(NUM_DIGITS)) ? StFull : StEntry;
          if (commit) pend_d = 1'b1;
`ifdef DECIMAL_ENTRY_ECHO_EN
          for (int i = NUM_DIGITS - 1; i > 0; i--) echo_d[i] = echo_q[i-1];
          echo_d[0] = seg7(digit_q);
`endif
        end
        StEntry, StFull: begin
          if (commit || pend_q) begin
            value_d = acc_q;
            vv_d    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = StEntry;
`ifdef DECIMAL_ENTRY_ECHO_EN
            echo_d  = '0;
`endif
          end
          // A transfer alongside a pending commit starts a fresh entry
          if (transfer) begin
            if (digit_in <= 4'd9) begin
              digit_d = digit_in;
              state_d = StCalc;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = StEntry;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StEntry;
      acc_q   <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      pend_q  <= 1'b0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DECIMAL_ENTRY_ECHO_EN
      echo_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      pend_q  <= pend_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
`ifdef DECIMAL_ENTRY_ECHO_EN
      echo_q  <= echo_d;
`endif
    end
  end

  assign value       = value_q;
  assign value_valid = vv_q;
  assign digit_count = cnt_q;
  assign digit_error = err_q;
`ifdef DECIMAL_ENTRY_ECHO_EN
  assign echo_seg    = echo_q;
`endif

endmodule

// File: tb/tb_decimal_entry_nbit.sv
// Self-checking bench for decimal_entry_nbit: directed scenarios plus randomized entries
// checked against an arithmetic model (value = sum of digits * 10^k).
module tb_decimal_entry_nbit;
  localparam int unsigned ND = 2;
  localparam int unsigned VW = $clog2(10**ND);
  localparam int unsigned CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          n_reset;
  logic [3:0]    digit_in;
  logic          digit_valid;
  logic          digit_ready;
  logic          commit;
  logic          clear;
  logic [VW-1:0] value;
  logic          value_valid;
  logic [CW-1:0] digit_count;
  logic          digit_error;
`ifdef DECIMAL_ENTRY_ECHO_EN
  logic [ND-1:0][6:0] echo_seg;
`endif

  int total = 0;
  int bad   = 0;
  int last_value = 0;

  decimal_entry_nbit #(.NUM_DIGITS(ND)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .commit      (commit),
    .clear       (clear),
    .value       (value),
    .value_valid (value_valid),
    .digit_count (digit_count),
`ifdef DECIMAL_ENTRY_ECHO_EN
    .digit_error (digit_error),
    .echo_seg    (echo_seg)
`else
    .digit_error (digit_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one digit when ready, then lets the CALC cycle complete.
  task automatic enter_digit(input int d);
    int w;
    w = 0;
    while (!digit_ready && w < 10) begin
      step();
      w++;
    end
    total++;
    if (digit_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: digit_ready=%0b required 1", digit_ready);
    end
    digit_in    = 4'(d);
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    step();
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    step();
    step();
    total++;
    if (value !== '0 || value_valid !== 1'b0 || digit_count !== '0 || digit_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: value=%0d vv=%0b cnt=%0d err=%0b required 0 0 0 0",
               value, value_valid, digit_count, digit_error);
    end
    total++;
    if (digit_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: digit_ready=%0b required 0", digit_ready);
    end
    n_reset = 1'b1;
    step();
    total++;
    if (digit_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready: digit_ready=%0b required 1", digit_ready);
    end
  endtask

  task automatic test_basic();
    enter_digit(4);
    enter_digit(2);
    total++;
    if (digit_count !== CW'(2)) begin
      bad++;
      $display("FAIL basic_count: digit_count=%0d required 2", digit_count);
    end
    pulse_commit();
    total++;
    if (value !== VW'(42) || value_valid !== 1'b1 || digit_count !== '0) begin
      bad++;
      $display("FAIL basic_commit: value=%0d vv=%0b cnt=%0d required 42 1 0",
               value, value_valid, digit_count);
    end
    step();
    total++;
    if (value_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_vv_pulse: value_valid=%0b required 0", value_valid);
    end
    last_value = 42;
  endtask

  task automatic test_full();
    enter_digit(9);
    enter_digit(9);
    digit_in    = 4'd5;
    digit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (digit_ready !== 1'b0 || digit_count !== CW'(2)) begin
        bad++;
        $display("FAIL full_hold: ready=%0b cnt=%0d required 0 2", digit_ready, digit_count);
      end
      step();
    end
    digit_valid = 1'b0;
    pulse_commit();
    total++;
    if (value !== VW'(99) || value_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_commit: value=%0d vv=%0b required 99 1", value, value_valid);
    end
    last_value = 99;
    step();
  endtask

  task automatic test_bad_digit();
    digit_in    = 4'd12;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    total++;
    if (digit_error !== 1'b1 || digit_count !== '0) begin
      bad++;
      $display("FAIL bad_digit_err: err=%0b cnt=%0d required 1 0", digit_error, digit_count);
    end
    step();
    total++;
    if (digit_error !== 1'b0) begin
      bad++;
      $display("FAIL bad_digit_pulse: err=%0b required 0", digit_error);
    end
    enter_digit(7);
    pulse_commit();
    total++;
    if (value !== VW'(7) || value_valid !== 1'b1) begin
      bad++;
      $display("FAIL bad_digit_then7: value=%0d vv=%0b required 7 1", value, value_valid);
    end
    last_value = 7;
    step();
  endtask

  task automatic test_clear_commit();
    enter_digit(3);
    clear  = 1'b1;
    commit = 1'b1;
    step();
    clear  = 1'b0;
    commit = 1'b0;
    total++;
    if (value_valid !== 1'b0 || value !== VW'(last_value) || digit_count !== '0) begin
      bad++;
      $display("FAIL clear_wins: vv=%0b value=%0d cnt=%0d required 0 %0d 0",
               value_valid, value, digit_count, last_value);
    end
    step();
    total++;
    if (value_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_wins_late: vv=%0b required 0", value_valid);
    end
  endtask

  task automatic test_commit_calc();
    digit_in    = 4'd5;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    commit      = 1'b1;
    step();
    commit      = 1'b0;
    total++;
    if (value_valid !== 1'b0) begin
      bad++;
      $display("FAIL pend_early: vv=%0b required 0", value_valid);
    end
    step();
    total++;
    if (value !== VW'(5) || value_valid !== 1'b1 || digit_count !== '0) begin
      bad++;
      $display("FAIL pend_commit: value=%0d vv=%0b cnt=%0d required 5 1 0",
               value, value_valid, digit_count);
    end
    step();
    // Second run: reset lands while the digit is in CALC
    digit_in    = 4'd6;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    n_reset     = 1'b0;
    #1;
    total++;
    if (value !== '0 || value_valid !== 1'b0 || digit_count !== '0 || digit_error !== 1'b0 ||
        digit_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_calc: value=%0d vv=%0b cnt=%0d err=%0b rdy=%0b required all 0",
               value, value_valid, digit_count, digit_error, digit_ready);
    end
    step();
    n_reset = 1'b1;
    step();
    pulse_commit();
    total++;
    if (value !== '0 || value_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_discard: value=%0d vv=%0b required 0 1", value, value_valid);
    end
    last_value = 0;
    step();
  endtask

  task automatic test_back_to_back();
    // Digit held valid: accepted once every two cycles
    digit_in    = 4'd3;
    digit_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    digit_valid = 1'b0;
    total++;
    if (digit_count !== CW'(2) || digit_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rate: cnt=%0d rdy=%0b required 2 0", digit_count, digit_ready);
    end
    commit = 1'b1;
    step();
    total++;
    if (value !== VW'(33) || value_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: value=%0d vv=%0b required 33 1", value, value_valid);
    end
    step();
    commit = 1'b0;
    total++;
    if (value !== '0 || value_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_empty_commit: value=%0d vv=%0b required 0 1", value, value_valid);
    end
    step();
    total++;
    if (value_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_vv_end: vv=%0b required 0", value_valid);
    end
    last_value = 0;
  endtask

  task automatic test_random();
    int k;
    int d;
    int b;
    int expv;
    for (int it = 0; it < 25; it++) begin
      expv = 0;
      k    = $urandom_range(0, ND);
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          b           = $urandom_range(10, 15);
          digit_in    = 4'(b);
          digit_valid = 1'b1;
          step();
          digit_valid = 1'b0;
          total++;
          if (digit_error !== 1'b1 || digit_count !== CW'(i)) begin
            bad++;
            $display("FAIL rand_bad_digit: err=%0b cnt=%0d required 1 %0d",
                     digit_error, digit_count, i);
          end
          step();
        end
        d = $urandom_range(0, 9);
        enter_digit(d);
        expv = expv * 10 + d;
        total++;
        if (digit_count !== CW'(i + 1)) begin
          bad++;
          $display("FAIL rand_count: cnt=%0d required %0d", digit_count, i + 1);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (value_valid !== 1'b0 || value !== VW'(last_value) || digit_count !== '0) begin
          bad++;
          $display("FAIL rand_clear: vv=%0b value=%0d cnt=%0d required 0 %0d 0",
                   value_valid, value, digit_count, last_value);
        end
      end else begin
        pulse_commit();
        total++;
        if (value_valid !== 1'b1 || value !== VW'(expv) || digit_count !== '0) begin
          bad++;
          $display("FAIL rand_commit: vv=%0b value=%0d cnt=%0d required 1 %0d 0",
                   value_valid, value, digit_count, expv);
        end
        last_value = expv;
      end
      step();
    end
  endtask

`ifdef DECIMAL_ENTRY_ECHO_EN
  task automatic test_echo();
    enter_digit(1);
    enter_digit(8);
    total++;
    if (echo_seg[0] !== 7'b1111111 || echo_seg[1] !== 7'b0000110) begin
      bad++;
      $display("FAIL echo_digits: seg0=%b seg1=%b required 1111111 0000110",
               echo_seg[0], echo_seg[1]);
    end
    pulse_commit();
    total++;
    if (echo_seg[0] !== 7'b0 || echo_seg[1] !== 7'b0 || value !== VW'(18)) begin
      bad++;
      $display("FAIL echo_blank: seg0=%b seg1=%b value=%0d required 0 0 18",
               echo_seg[0], echo_seg[1], value);
    end
    last_value = 18;
    step();
  endtask
`endif

  initial begin
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    commit      = 1'b0;
    clear       = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_bad_digit();
    test_clear_commit();
    test_commit_calc();
    test_back_to_back();
`ifdef DECIMAL_ENTRY_ECHO_EN
    test_echo();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decimal_entry_nbit.md
DECIMAL_ENTRY_NBIT -- requirements
Module: decimal_entry_nbit

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: maximum decimal digits accepted per entry.
REQ-002 SHALL have parameter VALUE_WIDTH, default $clog2(10**NUM_DIGITS): binary width of the accumulator and value.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port n_reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port digit_in  input  4: BCD digit offered.
REQ-006 SHALL have port digit_valid  input  1: digit_in is valid this cycle.
REQ-007 SHALL have port digit_ready  output  1: block accepts a digit this cycle.
REQ-008 SHALL have port commit  input  1: single-cycle pulse that publishes the entered number.
REQ-009 SHALL have port clear  input  1: single-cycle pulse that discards the entry.
REQ-010 SHALL have port value  output  VALUE_WIDTH: last committed number, unsigned binary.
REQ-011 SHALL have port value_valid  output  1: one-cycle pulse when value updates.
REQ-012 SHALL have port digit_count  output  $clog2(NUM_DIGITS+1): digits held in the current entry.
REQ-013 SHALL have port digit_error  output  1: one-cycle pulse on acceptance of a non-BCD digit.

Function
REQ-014 SHALL implement the FSM states ENTRY, CALC and FULL.
REQ-015 SHALL drive digit_ready = (state==ENTRY) & ~commit & ~clear.
REQ-016 SHALL define a transfer as digit_valid & digit_ready; transfers of 0-9 latch the digit and go ENTRY->CALC.
REQ-017 In CALC, SHALL update acc <= acc*10 + digit (shift-add: acc<<3 + acc<<1 + digit), increment digit_count, then go to FULL if digit_count==NUM_DIGITS, else to ENTRY; one digit per 2 cycles maximum.
REQ-018 On a transfer with digit_in>9, SHALL pulse digit_error on the next cycle and remain in ENTRY, leaving acc and digit_count unchanged.
REQ-019 In FULL, SHALL hold digit_ready low; offered digits are neither consumed nor stored.
REQ-020 On commit in ENTRY or FULL, SHALL do all of: value<=acc; pulse value_valid on the next cycle; clear acc and digit_count; go to ENTRY.
REQ-021 On commit in CALC, SHALL register it as pending and execute it in the cycle after CALC, using the updated acc.
REQ-022 On clear in any state, SHALL zero acc, digit_count and the pending commit and go to ENTRY; value SHALL be unchanged.
REQ-023 If clear and commit arrive together, clear SHALL win and value_valid SHALL stay low.
REQ-024 Commit with digit_count==0 SHALL publish value=0 and pulse value_valid.
REQ-025 acc SHALL never exceed 10**NUM_DIGITS-1 by construction, with no overflow or wrap.

Reset
REQ-026 n_reset low SHALL immediately force state=ENTRY and set acc, value, digit_count and the pending commit to 0, and value_valid and digit_error to 0.
REQ-027 Reset mid-CALC SHALL discard the in-flight digit.
REQ-028 digit_ready SHALL be low while n_reset is low.

Configuration
REQ-029 With the macro DECIMAL_ENTRY_ECHO_EN defined, SHALL add output echo_seg  NUM_DIGITS x 7: the entered digits in seven-segment form.
REQ-030 For echo_seg: bit0=a..bit6=g, active high; index 0 = most recent digit; positions not yet entered are blank (7'b0).
REQ-031 echo_seg SHALL update in the cycle after CALC and blank on commit, clear or reset.
REQ-032 Without DECIMAL_ENTRY_ECHO_EN, SHALL omit the echo_seg port and its logic; all other behaviour is identical.

Verification
REQ-033 NUM_DIGITS=2: enter 4 then 2, then commit -> value=42 with a one-cycle value_valid pulse; digit_count returns to 0.
REQ-034 Enter 9, 9, then offer 5 -> digit_ready low in FULL, 5 not consumed; commit -> value=99.
REQ-035 Offer digit 12 with digit_valid high -> digit_error pulse, digit_count unchanged; then enter 7, commit -> value=7.
REQ-036 Enter 3, then assert clear and commit in the same cycle -> no value_valid, value keeps its previous value, digit_count=0.
REQ-037 Enter 5 and commit during CALC -> value=5 published one cycle after CALC; assert n_reset low mid-CALC on a second run -> all outputs 0.
REQ-038 With DECIMAL_ENTRY_ECHO_EN: enter 1, 8 -> echo_seg[0]=7'b1111111, echo_seg[1]=7'b0000110; commit -> both 7'b0.
